img2col_layer_sched: RTL
========================

IMG2COL_LAYER_SCHED -- requirements
Module: img2col_layer_sched

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, SHALL set the number of layer-config table entries (power of two, 2..16).
REQ-002 Parameter LANE, default 8, SHALL set the bytes per 64-bit beat used in derived-count arithmetic.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_we  input  1  table write strobe; cfg_addr  input  log2(NUM_ENTRIES)  entry index.
REQ-006 cfg_wdata  input  48  packed entry: [47:44] stride, [43:40] kernel, [39:30] in_size, [29:20] in_ch, [19:10] out_ch, [9:0] out_size.
REQ-007 go  input  1  start sequence; num_layers  input  log2(NUM_ENTRIES)+1  layers to run (1..NUM_ENTRIES); abort  input  1  cancel sequence.
REQ-008 i2c_last, i2c_valid, i2c_ready  input  1 each  mLast/mValid/mReady of the sequenced Img2Col datapath output.
REQ-009 i2c_start  output  1  one-cycle start pulse to the datapath.
REQ-010 Config outputs to the datapath: stride 4, kernel_size 4, in_size 10, in_ch 10, out_ch 10, out_size 10, window_size 16, sliding_size 10, in_col_times 16, out_col_times 10, out_row_times 10, out_ch_times 10.
REQ-011 busy  output  1; done  output  1 (one-cycle pulse); err  output  1 (sticky); layer_idx  output  log2(NUM_ENTRIES).

Function
REQ-012 Table write SHALL take effect the cycle after cfg_we; writes while busy=1 SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, LOAD, START, RUN, NEXT, FINISH.
REQ-014 IDLE->LOAD on go=1 with 1<=num_layers<=NUM_ENTRIES; layer_idx<=0, num_layers latched; go with num_layers out of range SHALL set err and stay IDLE.
REQ-015 LOAD (1 cycle) SHALL register all config outputs from entry layer_idx and derived values: sliding_size=in_ch/LANE, window_size=kernel*sliding_size, in_col_times=in_size*sliding_size, out_col_times=ceil(out_size/LANE), out_ch_times=ceil(out_ch/LANE), out_row_times=out_size.
REQ-016 Derived arithmetic SHALL be unsigned and zero-extended; LANE division SHALL be shift-based; no runtime divider.
REQ-017 LOAD SHALL set err and go to FINISH when in_ch mod LANE !=0, kernel=0, stride=0, or out_size=0.
REQ-018 START SHALL assert i2c_start for exactly one cycle, then enter RUN.
REQ-019 RUN SHALL wait for i2c_last & i2c_valid & i2c_ready in the same cycle; i2c_last alone SHALL NOT advance.
REQ-020 NEXT: if layer_idx=num_layers-1 go FINISH, else layer_idx+1 and LOAD.
REQ-021 FINISH SHALL pulse done one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-022 Config outputs SHALL hold stable from LOAD exit through RUN exit.
REQ-023 abort=1 in any non-IDLE state SHALL go to FINISH next cycle (done pulses, err unchanged); abort has priority over the RUN completion event in the same cycle.
REQ-024 go while busy SHALL be ignored; err SHALL clear only on reset or an accepted go.

Reset
REQ-025 reset SHALL force IDLE; i2c_start, busy, done, err = 0; layer_idx = 0; all config outputs = 0; table contents SHALL be zeroed.
REQ-026 reset asserted mid-RUN SHALL take effect next edge with no start or done pulse emitted.

Structure
REQ-027 Shared package SHALL hold the cfg_wdata field offsets/widths, FSM state encoding, and LANE default.
REQ-028 One sub-module, img2col_cfg_derive (combinational derived-count calculator), SHALL be instantiated in LOAD path.

Verification
REQ-029 Write entry0 {1,3,225,48,35,223}, go num_layers=1 -> window 18, sliding 6, in_col 1350, out_col 28, out_ch_times 5, out_row 223; one i2c_start 2 cycles after go.
REQ-030 Two layers programmed; drive last handshake for layer0 -> layer_idx=1, second i2c_start 3 cycles later; second handshake -> done pulse, busy=0.
REQ-031 i2c_last=1 with i2c_ready=0 for 10 cycles -> remains RUN, no done; ready=1 -> NEXT.
REQ-032 Entry with in_ch=50 -> err=1, done pulse, no i2c_start.
REQ-033 abort in RUN coincident with last handshake -> FINISH, done pulse, layer_idx not incremented.
REQ-034 reset pulsed mid-RUN -> all outputs 0, table zero, subsequent go num_layers=0 -> err=1.

Source files
------------

// File: rtl/img2col_layer_sched_pkg.sv
// Shared definitions for the Img2Col layer sequencer: the packed layer-entry
// field layout, the sequencer state encoding and the default beat width.
package img2col_layer_sched_pkg;

    // Bytes per 64-bit beat
    localparam int LANE_DEFAULT = 8;

    // Packed layer-config entry layout
    localparam int ENTRY_W      = 48;
    localparam int STRIDE_LSB   = 44;
    localparam int STRIDE_W     = 4;
    localparam int KERNEL_LSB   = 40;
    localparam int KERNEL_W     = 4;
    localparam int IN_SIZE_LSB  = 30;
    localparam int IN_SIZE_W    = 10;
    localparam int IN_CH_LSB    = 20;
    localparam int IN_CH_W      = 10;
    localparam int OUT_CH_LSB   = 10;
    localparam int OUT_CH_W     = 10;
    localparam int OUT_SIZE_LSB = 0;
    localparam int OUT_SIZE_W   = 10;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } sched_state_t;

endpackage

// File: rtl/img2col_layer_sched_derive.sv
// Combinational derived-count calculator for one layer entry.
// LANE must be a power of two, so every division by LANE is a right shift.
module img2col_cfg_derive
    import img2col_layer_sched_pkg::*;
#(
    parameter int LANE = LANE_DEFAULT
) (
    input  logic [3:0]  stride,
    input  logic [3:0]  kernel,
    input  logic [9:0]  in_size,
    input  logic [9:0]  in_ch,
    input  logic [9:0]  out_ch,
    input  logic [9:0]  out_size,
    output logic [15:0] window_size,
    output logic [9:0]  sliding_size,
    output logic [15:0] in_col_times,
    output logic [9:0]  out_col_times,
    output logic [9:0]  out_ch_times,
    output logic [9:0]  out_row_times,
    output logic        cfg_ok
);

    localparam int          LANE_SH = $clog2(LANE);
    localparam logic [10:0] LANE_M1 = 11'(LANE - 1);

    logic [9:0] sliding_s;

    // Derived counts; sums are widened by one bit so the ceiling cannot wrap
    always_comb begin
        sliding_s     = in_ch >> LANE_SH;
        sliding_size  = sliding_s;
        window_size   = 16'(kernel) * 16'(sliding_s);
        in_col_times  = 16'(in_size) * 16'(sliding_s);
        out_col_times = 10'(({1'b0, out_size} + LANE_M1) >> LANE_SH);
        out_ch_times  = 10'(({1'b0, out_ch} + LANE_M1) >> LANE_SH);
        out_row_times = out_size;
        cfg_ok        = ((in_ch & LANE_M1[9:0]) == 10'd0) &&
                        (kernel != 4'd0) && (stride != 4'd0) &&
                        (out_size != 10'd0);
    end

endmodule

// File: rtl/img2col_layer_sched.sv
// Layer sequencer for the Img2Col datapath: holds a small table of layer
// configurations and walks through the first num_layers entries, loading
// each one, pulsing i2c_start and waiting for the final output handshake.
module img2col_layer_sched
    import img2col_layer_sched_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int LANE        = LANE_DEFAULT,
    localparam int AW         = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [47:0]       cfg_wdata,
    input  logic              go,
    input  logic [AW:0]       num_layers,
    input  logic              abort,
    input  logic              i2c_last,
    input  logic              i2c_valid,
    input  logic              i2c_ready,
    output logic              i2c_start,
    output logic [3:0]        stride,
    output logic [3:0]        kernel_size,
    output logic [9:0]        in_size,
    output logic [9:0]        in_ch,
    output logic [9:0]        out_ch,
    output logic [9:0]        out_size,
    output logic [15:0]       window_size,
    output logic [9:0]        sliding_size,
    output logic [15:0]       in_col_times,
    output logic [9:0]        out_col_times,
    output logic [9:0]        out_row_times,
    output logic [9:0]        out_ch_times,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     layer_idx
);

    sched_state_t state_r, state_n;

    logic [ENTRY_W-1:0] table_r [NUM_ENTRIES];
    logic [ENTRY_W-1:0] entry_s;
    logic [AW:0]        num_layers_r;
    logic [AW-1:0]      layer_idx_r;
    logic               busy_r, done_r, err_r, start_r;

    logic               accept_s, err_set_s, adv_s, range_ok_s, last_layer_s, hs_s;

    logic [3:0]  f_stride_s, f_kernel_s;
    logic [9:0]  f_in_size_s, f_in_ch_s, f_out_ch_s, f_out_size_s;
    logic [15:0] d_window_s, d_in_col_s;
    logic [9:0]  d_sliding_s, d_out_col_s, d_out_ch_s, d_out_row_s;
    logic        d_ok_s;

    // Field extraction of the entry being loaded
    always_comb begin
        entry_s      = table_r[layer_idx_r];
        f_stride_s   = entry_s[STRIDE_LSB   +: STRIDE_W];
        f_kernel_s   = entry_s[KERNEL_LSB   +: KERNEL_W];
        f_in_size_s  = entry_s[IN_SIZE_LSB  +: IN_SIZE_W];
        f_in_ch_s    = entry_s[IN_CH_LSB    +: IN_CH_W];
        f_out_ch_s   = entry_s[OUT_CH_LSB   +: OUT_CH_W];
        f_out_size_s = entry_s[OUT_SIZE_LSB +: OUT_SIZE_W];
    end

    img2col_cfg_derive #(.LANE(LANE)) u_derive (
        .stride        (f_stride_s),
        .kernel        (f_kernel_s),
        .in_size       (f_in_size_s),
        .in_ch         (f_in_ch_s),
        .out_ch        (f_out_ch_s),
        .out_size      (f_out_size_s),
        .window_size   (d_window_s),
        .sliding_size  (d_sliding_s),
        .in_col_times  (d_in_col_s),
        .out_col_times (d_out_col_s),
        .out_ch_times  (d_out_ch_s),
        .out_row_times (d_out_row_s),
        .cfg_ok        (d_ok_s)
    );

    // Qualifiers used by the next-state logic
    always_comb begin
        range_ok_s   = (num_layers != '0) && (num_layers <= (AW+1)'(NUM_ENTRIES));
        last_layer_s = (({1'b0, layer_idx_r} + (AW+1)'(1)) == num_layers_r);
        hs_s         = i2c_last & i2c_valid & i2c_ready;
    end

    // Next-state logic; abort outranks every other event outside IDLE
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        err_set_s = 1'b0;
        adv_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    if (range_ok_s) begin
                        accept_s = 1'b1;
                        state_n  = ST_LOAD;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_n = ST_FINISH;
                end else if (!d_ok_s) begin
                    err_set_s = 1'b1;
                    state_n   = ST_FINISH;
                end else begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (abort) begin
                    state_n = ST_FINISH;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_FINISH;
                end else if (hs_s) begin
                    state_n = ST_NEXT;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_n = ST_FINISH;
                end else if (last_layer_s) begin
                    state_n = ST_FINISH;
                end else begin
                    adv_s   = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            start_r      <= 1'b0;
            err_r        <= 1'b0;
            layer_idx_r  <= '0;
            num_layers_r <= '0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n != ST_IDLE);
            done_r  <= (state_n == ST_FINISH);
            start_r <= (state_n == ST_START);
            if (accept_s) begin
                err_r        <= 1'b0;
                layer_idx_r  <= '0;
                num_layers_r <= num_layers;
            end else begin
                if (err_set_s) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
                if (adv_s) begin
                    layer_idx_r <= layer_idx_r + AW'(1);
                end else begin
                    layer_idx_r <= layer_idx_r;
                end
            end
        end
    end

    // Layer-config table; writes are only accepted while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                table_r[i] <= '0;
            end
        end else if (cfg_we && (state_r == ST_IDLE)) begin
            table_r[cfg_addr] <= cfg_wdata;
        end
    end

    // Config outputs captured in LOAD and held until the next LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            stride        <= '0;
            kernel_size   <= '0;
            in_size       <= '0;
            in_ch         <= '0;
            out_ch        <= '0;
            out_size      <= '0;
            window_size   <= '0;
            sliding_size  <= '0;
            in_col_times  <= '0;
            out_col_times <= '0;
            out_row_times <= '0;
            out_ch_times  <= '0;
        end else if (state_r == ST_LOAD) begin
            stride        <= f_stride_s;
            kernel_size   <= f_kernel_s;
            in_size       <= f_in_size_s;
            in_ch         <= f_in_ch_s;
            out_ch        <= f_out_ch_s;
            out_size      <= f_out_size_s;
            window_size   <= d_window_s;
            sliding_size  <= d_sliding_s;
            in_col_times  <= d_in_col_s;
            out_col_times <= d_out_col_s;
            out_row_times <= d_out_row_s;
            out_ch_times  <= d_out_ch_s;
        end
    end

    assign i2c_start = start_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign layer_idx = layer_idx_r;

endmodule
